// File: rtl/mem_pkg.sv
// Shared types, constants and lane helpers for the memory-stage controller.
package mem_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 32;
  localparam int VEC_W  = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  // Memory-stage sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // Extract lane idx from a packed vector (lane k lives at bits [32k+31:32k]).
  function automatic logic [LANE_W-1:0] lane_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [CNT_W-1:0] idx);
    return vec[int'(idx)*LANE_W +: LANE_W];
  endfunction

  // Return vec with lane idx replaced by val.
  function automatic logic [VEC_W-1:0] lane_put(input logic [VEC_W-1:0]  vec,
                                                input logic [CNT_W-1:0]  idx,
                                                input logic [LANE_W-1:0] val);
    logic [VEC_W-1:0] r;
    r = vec;
    r[int'(idx)*LANE_W +: LANE_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_buffer.sv
// Six-lane register file: holds store data for a write burst, or assembles
// load data lane by lane for a read burst. Falling-edge, async active-low reset.
module mem_lane_buffer
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [VEC_W-1:0]  load_vec_i,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  widx_i,
  input  logic [LANE_W-1:0] wdata_i,
  output logic [VEC_W-1:0]  vec_o
);

  logic [LANE_W-1:0] lane_q [LANES];

  // Clear has priority over a full load, which has priority over a single-lane write.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (load_i) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= load_vec_i[k*LANE_W +: LANE_W];
    end else if (we_i && (int'(widx_i) < LANES)) begin
      lane_q[widx_i] <= wdata_i;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_flat
    assign vec_o[g*LANE_W +: LANE_W] = lane_q[g];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: sequences scalar (1-beat) or vector (LANES-beat)
// accesses to a single-port synchronous RAM, stalls upstream while a burst is
// in flight, and registers the finished result (or a bubble) towards MEM/WB.
// All state advances on the falling clock edge.
//
// Handshake: there is no valid/ready pair upstream. An op presented in IDLE is
// taken on the edge where stall = 0; while stall = 1 upstream must hold its
// inputs unchanged. Downstream sees valid_out = 1 for exactly one cycle per
// instruction and valid_out = 0 (all other outputs zero) on every bubble.
module mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 6,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    MemToReg_in,
  input  logic                    MemRead_in,
  input  logic                    MemWrite_in,
  input  logic                    VectorOp_in,
  input  logic [LANES*LANE_W-1:0] alu_in,
  input  logic [LANES*LANE_W-1:0] mux1_in,
  input  logic [3:0]              RR_in,
  output logic                    stall,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [LANE_W-1:0]       mem_rdata,
  output logic                    valid_out,
  output logic                    MemToReg_out,
  output logic                    VectorOp_out,
  output logic [3:0]              RR_out,
  output logic [LANES*LANE_W-1:0] alu_out,
  output logic [LANES*LANE_W-1:0] rdata_out,
  output logic [1:0]              dbg_state
);

  import mem_pkg::*;

  localparam int VW = LANES * LANE_W;
  localparam int CW = $clog2(LANES);

  // Sequencer state and beat counter.
  mem_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Op latched when a memory access is accepted in IDLE.
  logic [ADDR_W-1:0] base_q;
  logic [CW-1:0]     last_q;
  logic              wr_q;
  logic              mtr_q;
  logic              vec_q;
  logic [3:0]        rr_q;
  logic [VW-1:0]     alu_q;

  // Registered MEM/WB-facing outputs.
  logic              valid_q, valid_d;
  logic              mtr_out_q, mtr_out_d;
  logic              vop_out_q, vop_out_d;
  logic [3:0]        rr_out_q, rr_out_d;
  logic [VW-1:0]     alu_out_q, alu_out_d;
  logic [VW-1:0]     rdata_out_q, rdata_out_d;

  // Lane buffer controls.
  logic              buf_clr;
  logic              buf_load;
  logic              buf_we;
  logic [CW-1:0]     buf_widx;
  logic [VW-1:0]     buf_vec;

  logic              mem_op;
  logic [ADDR_W-1:0] beat_addr;

  assign mem_op    = MemRead_in | MemWrite_in;
  // Address arithmetic deliberately wraps modulo 2^ADDR_W.
  assign beat_addr = base_q + ADDR_W'(cnt_q);

  mem_lane_buffer u_lane_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (buf_clr),
    .load_i     (buf_load),
    .load_vec_i (mux1_in),
    .we_i       (buf_we),
    .widx_i     (buf_widx),
    .wdata_i    (mem_rdata),
    .vec_o      (buf_vec)
  );

  // State register.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state: a write wins when both read and write are requested.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (mem_op) state_d = MemWrite_in ? WRITE : READ;
      WRITE: if (cnt_q == last_q) state_d = DONE;
      READ:  if (cnt_q == last_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM strobes, stall, lane-buffer control and next MEM/WB values.
  always_comb begin
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    buf_clr     = 1'b0;
    buf_load    = 1'b0;
    buf_we      = 1'b0;
    buf_widx    = last_q;
    cnt_d       = '0;
    valid_d     = 1'b0;
    mtr_out_d   = 1'b0;
    vop_out_d   = 1'b0;
    rr_out_d    = '0;
    alu_out_d   = '0;
    rdata_out_d = '0;
    unique case (state_q)
      IDLE: begin
        stall = mem_op;
        if (mem_op) begin
          // Stores keep their data in the buffer; loads start from all-zero lanes.
          buf_load = MemWrite_in;
          buf_clr  = ~MemWrite_in;
        end else begin
          valid_d   = 1'b1;
          mtr_out_d = MemToReg_in;
          vop_out_d = VectorOp_in;
          rr_out_d  = RR_in;
          alu_out_d = alu_in;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = lane_sel(buf_vec, cnt_q);
        cnt_d     = cnt_q + CW'(1);
      end
      READ: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = beat_addr;
        cnt_d    = cnt_q + CW'(1);
        // Data for the previous beat's address is on mem_rdata this cycle.
        if (cnt_q != '0) begin
          buf_we   = 1'b1;
          buf_widx = cnt_q - CW'(1);
        end
      end
      DONE: begin
        valid_d   = 1'b1;
        mtr_out_d = mtr_q;
        vop_out_d = vec_q;
        rr_out_d  = rr_q;
        alu_out_d = alu_q;
        if (!wr_q) begin
          // Last lane arrives now, so the result bypasses the buffer for it.
          buf_we      = 1'b1;
          buf_widx    = last_q;
          rdata_out_d = lane_put(buf_vec, last_q, mem_rdata);
        end
      end
      default: ;
    endcase
  end

  // Beat counter and op latch.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      base_q <= '0;
      last_q <= '0;
      wr_q   <= 1'b0;
      mtr_q  <= 1'b0;
      vec_q  <= 1'b0;
      rr_q   <= '0;
      alu_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == IDLE && mem_op) begin
        base_q <= alu_in[ADDR_W-1:0];
        last_q <= VectorOp_in ? CW'(LANES - 1) : '0;
        wr_q   <= MemWrite_in;
        mtr_q  <= MemToReg_in;
        vec_q  <= VectorOp_in;
        rr_q   <= RR_in;
        alu_q  <= alu_in;
      end
    end
  end

  // MEM/WB output registers; stalled edges load the all-zero bubble.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      mtr_out_q   <= 1'b0;
      vop_out_q   <= 1'b0;
      rr_out_q    <= '0;
      alu_out_q   <= '0;
      rdata_out_q <= '0;
    end else begin
      valid_q     <= valid_d;
      mtr_out_q   <= mtr_out_d;
      vop_out_q   <= vop_out_d;
      rr_out_q    <= rr_out_d;
      alu_out_q   <= alu_out_d;
      rdata_out_q <= rdata_out_d;
    end
  end

  assign valid_out    = valid_q;
  assign MemToReg_out = mtr_out_q;
  assign VectorOp_out = vop_out_q;
  assign RR_out       = rr_out_q;
  assign alu_out      = alu_out_q;
  assign rdata_out    = rdata_out_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard monitor on RAM beats
// and MEM/WB results.
module tb_mem_access_unit;

  localparam int AW = 16;
  localparam int VW = 192;
  localparam int OW = 390;  // {MemToReg, VectorOp, RR[3:0], alu[191:0], rdata[191:0]}

  logic          clk;
  logic          rst;
  logic          MemToReg_in, MemRead_in, MemWrite_in, VectorOp_in;
  logic [VW-1:0] alu_in, mux1_in;
  logic [3:0]    RR_in;
  logic          stall;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we, mem_re;
  logic [31:0]   mem_rdata;
  logic          valid_out, MemToReg_out, VectorOp_out;
  logic [3:0]    RR_out;
  logic [VW-1:0] alu_out, rdata_out;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int bubble_cnt = 0;

  logic [OW-1:0] exp_out_q[$];
  logic [47:0]   exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];

  logic [31:0] ram [0:65535];

  mem_access_unit #(.ADDR_W(16), .LANES(6), .LANE_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemToReg_in  (MemToReg_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .VectorOp_in  (VectorOp_in),
    .alu_in       (alu_in),
    .mux1_in      (mux1_in),
    .RR_in        (RR_in),
    .stall        (stall),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .valid_out    (valid_out),
    .MemToReg_out (MemToReg_out),
    .VectorOp_out (VectorOp_out),
    .RR_out       (RR_out),
    .alu_out      (alu_out),
    .rdata_out    (rdata_out),
    .dbg_state    (dbg_state)
  );

  // Clock and reset: falling edge is the active edge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, preloaded with {A5A5, address}.
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = {16'hA5A5, 16'(i)};
    mem_rdata <= '0;
    forever begin
      @(negedge clk);
      if (mem_we) ram[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_out(input logic mtr, input logic vop, input logic [3:0] rr,
                          input logic [VW-1:0] alu, input logic [VW-1:0] rdata);
    exp_out_q.push_back({mtr, vop, rr, alu, rdata});
  endtask

  // Scoreboard monitor: samples mid-cycle, away from the falling edge.
  always @(posedge clk) begin
    if (mem_we || mem_re) check("strobe_exclusive", OW'(mem_we & mem_re), '0);
    if (mem_we) begin
      if (exp_wr_q.size() == 0) fail("unexpected_mem_we");
      else check("write_beat", OW'({mem_addr, mem_wdata}), OW'(exp_wr_q.pop_front()));
    end
    if (mem_re) begin
      if (exp_rd_q.size() == 0) fail("unexpected_mem_re");
      else check("read_beat_addr", OW'(mem_addr), OW'(exp_rd_q.pop_front()));
    end
    if (valid_out === 1'b1) begin
      if (exp_out_q.size() == 0) fail("unexpected_valid_out");
      else check("result", {MemToReg_out, VectorOp_out, RR_out, alu_out, rdata_out},
                 exp_out_q.pop_front());
    end else begin
      bubble_cnt++;
      check("bubble_zero", {MemToReg_out, VectorOp_out, RR_out, alu_out, rdata_out}, '0);
    end
  end

  // Present one op, wait until it is accepted, then confirm its result slot.
  // Called just after a rising edge; returns just after the next rising edge.
  task automatic do_op(input logic mtr, input logic rd, input logic wr, input logic vec,
                       input logic [VW-1:0] alu, input logic [VW-1:0] wd,
                       input logic [3:0] rr, input int exp_stall, input string name);
    int stalls;
    bit s;
    bit done;
    MemToReg_in = mtr;
    MemRead_in  = rd;
    MemWrite_in = wr;
    VectorOp_in = vec;
    alu_in      = alu;
    mux1_in     = wd;
    RR_in       = rr;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      #1;
      s = stall;
      @(negedge clk);
      if (!s) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) fail({name, "_timeout"});
    @(posedge clk);
    #1;
    check({name, "_valid"}, OW'(valid_out), OW'(1));
    check({name, "_stalls"}, OW'(stalls), OW'(exp_stall));
    #1;
  endtask

  logic [VW-1:0] vec_data;
  logic [VW-1:0] alu_v;
  int            b0;

  initial begin
    rst = 1'b0;
    MemToReg_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; VectorOp_in = 1'b0;
    alu_in = '0; mux1_in = '0; RR_in = '0;
    vec_data = 192'h00000066_00000055_00000044_00000033_00000022_00000011;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", OW'(valid_out), '0);
    check("rst_stall", OW'(stall), '0);
    check("rst_strobes", OW'({mem_we, mem_re}), '0);
    check("rst_state", OW'(dbg_state), '0);
    check("rst_outputs", {MemToReg_out, VectorOp_out, RR_out, alu_out, rdata_out}, '0);
    #1 rst = 1'b1;

    // Scalar store.
    exp_wr_q.push_back({16'h0010, 32'hDEADBEEF});
    push_out(1'b0, 1'b0, 4'h3, 192'h10, '0);
    do_op(1'b0, 1'b0, 1'b1, 1'b0, 192'h10, 192'hDEADBEEF, 4'h3, 2, "scalar_store");

    // Vector store then vector load, back to back.
    for (int k = 0; k < 6; k++) exp_wr_q.push_back({16'h0100 + 16'(k), 32'h11 * (k + 1)});
    push_out(1'b0, 1'b1, 4'h5, 192'h0100, '0);
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 192'h0100, vec_data, 4'h5, 7, "vec_store");

    for (int k = 0; k < 6; k++) exp_rd_q.push_back(16'h0100 + 16'(k));
    push_out(1'b1, 1'b1, 4'h6, 192'h0100, vec_data);
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 192'h0100, '0, 4'h6, 7, "vec_load");

    // Vector load across the top of the address space.
    for (int k = 0; k < 6; k++) exp_rd_q.push_back(16'hFFFE + 16'(k));
    push_out(1'b0, 1'b1, 4'h2, 192'hFFFE,
             192'hA5A50003_A5A50002_A5A50001_A5A50000_A5A5FFFF_A5A5FFFE);
    do_op(1'b0, 1'b1, 1'b0, 1'b1, 192'hFFFE, '0, 4'h2, 7, "wrap_load");

    // Pass-through, then a vector store whose stalled edges must be bubbles.
    alu_v = {24{8'h5A}};
    push_out(1'b1, 1'b0, 4'h7, alu_v, '0);
    do_op(1'b1, 1'b0, 1'b0, 1'b0, alu_v, 192'h1234, 4'h7, 0, "pass_through");
    b0 = bubble_cnt;
    for (int k = 0; k < 6; k++) exp_wr_q.push_back({16'h0300 + 16'(k), 32'h11 * (k + 1)});
    push_out(1'b0, 1'b1, 4'h8, 192'h0300, '0);
    do_op(1'b0, 1'b0, 1'b1, 1'b1, 192'h0300, vec_data, 4'h8, 7, "vec_store2");
    check("bubble_count", OW'(bubble_cnt - b0), OW'(7));

    // Conflicting controls act as a write; read back to confirm.
    exp_wr_q.push_back({16'h0020, 32'hCAFEF00D});
    push_out(1'b0, 1'b0, 4'h2, 192'h20, '0);
    do_op(1'b0, 1'b1, 1'b1, 1'b0, 192'h20, 192'hCAFEF00D, 4'h2, 2, "conflict_write");
    exp_rd_q.push_back(16'h0020);
    push_out(1'b1, 1'b0, 4'h1, 192'h20, 192'hCAFEF00D);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 192'h20, '0, 4'h1, 2, "conflict_readback");

    // Reset during beat 3 of a vector load.
    for (int k = 0; k < 3; k++) exp_rd_q.push_back(16'h0200 + 16'(k));
    MemToReg_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; VectorOp_in = 1'b1;
    alu_in = 192'h0200; mux1_in = '0; RR_in = 4'h9;
    #1 check("abort_stall_start", OW'(stall), OW'(1));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    MemRead_in = 1'b0; VectorOp_in = 1'b0; MemToReg_in = 1'b0; alu_in = '0; RR_in = '0;
    #1;
    check("abort_stall", OW'(stall), '0);
    check("abort_strobes", OW'({mem_we, mem_re}), '0);
    check("abort_state", OW'(dbg_state), '0);
    check("abort_outputs", {valid_out, MemToReg_out, VectorOp_out, RR_out, alu_out, rdata_out}, '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    exp_rd_q.push_back(16'h0010);
    push_out(1'b1, 1'b0, 4'h4, 192'h10, 192'hDEADBEEF);
    do_op(1'b1, 1'b1, 1'b0, 1'b0, 192'h10, '0, 4'h4, 2, "post_reset_load");

    // Park in reset and confirm nothing is left outstanding.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("out_q_empty", OW'(exp_out_q.size()), '0);
    check("wr_q_empty", OW'(exp_wr_q.size()), '0);
    check("rd_q_empty", OW'(exp_rd_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
